lbus_regmap_param: RTL and testbench



---
 rtl/lbus_regmap_param.sv | 73 +++++++
 tb/tb_lbus_regmap_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lbus_regmap_param.sv
// lbus_regmap_param: parameterised lbus register map with synchronised strobes,
// read-only/self-clearing attributes, per-register write strobes and error count.
module lbus_regmap_param #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 8,
   parameter int NUM_REGS = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK = {NUM_REGS{1'b0}},
   parameter logic [NUM_REGS-1:0] SC_MASK = {NUM_REGS{1'b0}},
   parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = {NUM_REGS*DATA_W{1'b0}}
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         rd_en_sclk,
   input  logic                         wr_en_sclk,
   input  logic [ADDR_W-1:0]            address_sclk,
   input  logic [DATA_W-1:0]            wdata_sclk,
   input  logic [NUM_REGS*DATA_W-1:0]   status_in,
   output logic [DATA_W-1:0]            rdata,
   output logic [NUM_REGS*DATA_W-1:0]   regs_out,
   output logic [NUM_REGS-1:0]          wr_strobe,
   output logic [7:0]                   wr_err_cnt
);
   localparam int IW = $clog2(NUM_REGS);
   localparam logic [ADDR_W:0] NR = (ADDR_W+1)'(NUM_REGS);
   logic rd_ff1_q, rd_ff2_q, rd_hold_q, wr_ff1_q, wr_ff2_q, wr_hold_q;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [NUM_REGS-1:0] wr_strobe_q, wr_strobe_d;
   logic [7:0] err_q, err_d;
   logic rd_pulse, wr_pulse, in_range, wr_ok;
   logic [IW-1:0] idx;
   assign rd_pulse = rd_ff2_q & ~rd_hold_q;
   assign wr_pulse = wr_ff2_q & ~wr_hold_q;
   assign in_range = {1'b0, address_sclk} < NR;
   assign idx = address_sclk[IW-1:0];
   assign wr_ok = wr_pulse & in_range & ~RO_MASK[idx];
   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < NUM_REGS; i++)
         if (SC_MASK[i]) regs_d[i] = RESET_VAL[i*DATA_W +: DATA_W];
      if (wr_ok) regs_d[idx] = wdata_sclk;
      wr_strobe_d = wr_ok ? NUM_REGS'(1) << idx : '0;
      err_d = (wr_pulse & ~wr_ok & (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
      // regs_q is read before this edge's write lands, so a same-cycle read sees the old value
      rdata_d = !rd_pulse ? rdata_q :
                !in_range ? '0 :
                RO_MASK[idx] ? status_in[idx*DATA_W +: DATA_W] : regs_q[idx];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {rd_ff1_q, rd_ff2_q, rd_hold_q} <= '0;
         {wr_ff1_q, wr_ff2_q, wr_hold_q} <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
         rdata_q <= '0;
         wr_strobe_q <= '0;
         err_q <= '0;
      end else begin
         {rd_ff1_q, rd_ff2_q, rd_hold_q} <= {rd_en_sclk, rd_ff1_q, rd_ff2_q};
         {wr_ff1_q, wr_ff2_q, wr_hold_q} <= {wr_en_sclk, wr_ff1_q, wr_ff2_q};
         regs_q <= regs_d;
         rdata_q <= rdata_d;
         wr_strobe_q <= wr_strobe_d;
         err_q <= err_d;
      end
   end
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign regs_out[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : regs_q[g];
   end
   assign rdata = rdata_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_err_cnt = err_q;
endmodule

// File: tb/tb_lbus_regmap_param.sv
// tb_lbus_regmap_param: table-driven, randomized and corner-case checks of two
// regmap instances against an array-based register model.
module tb_lbus_regmap_param;
   localparam logic [7:0] RO_A = 8'h80;
   localparam logic [7:0] SC_A = 8'h01;
   localparam logic [63:0] RV_A = 64'h0000_0000_0000_4200;
   localparam logic [511:0] RV_B = {16'h1234, 496'h0};
   logic clk = 1'b0, rst_n = 1'b0;
   logic rd_en_a = 0, wr_en_a = 0, rd_en_b = 0, wr_en_b = 0;
   logic [23:0] addr_a = 0, addr_b = 0;
   logic [7:0] wdata_a = 0, rdata_a, err_a, strobe_a;
   logic [63:0] status_a = 64'h5C11_2233_4455_6677, regs_a;
   logic [15:0] wdata_b = 0, rdata_b;
   logic [511:0] status_b = '0, regs_b;
   logic [31:0] strobe_b;
   logic [7:0] err_b;
   logic [7:0] mdl [8];
   int merr;
   int n_chk = 0, n_fail = 0;
   lbus_regmap_param #(.RO_MASK(RO_A), .SC_MASK(SC_A), .RESET_VAL(RV_A)) u_a (
      .clk(clk), .rst_n(rst_n), .rd_en_sclk(rd_en_a), .wr_en_sclk(wr_en_a),
      .address_sclk(addr_a), .wdata_sclk(wdata_a), .status_in(status_a),
      .rdata(rdata_a), .regs_out(regs_a), .wr_strobe(strobe_a), .wr_err_cnt(err_a));
   lbus_regmap_param #(.DATA_W(16), .NUM_REGS(32), .RESET_VAL(RV_B)) u_b (
      .clk(clk), .rst_n(rst_n), .rd_en_sclk(rd_en_b), .wr_en_sclk(wr_en_b),
      .address_sclk(addr_b), .wdata_sclk(wdata_b), .status_in(status_b),
      .rdata(rdata_b), .regs_out(regs_b), .wr_strobe(strobe_b), .wr_err_cnt(err_b));
   always #5 clk = ~clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end
   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask
   function automatic logic [63:0] flat_a(input int wa, input logic [7:0] wd);
      logic [63:0] f;
      f = '0;
      for (int i = 0; i < 8; i++) if (!RO_A[i]) f[i*8 +: 8] = (i == wa) ? wd : mdl[i];
      return f;
   endfunction
   task automatic model_reset();
      for (int i = 0; i < 8; i++) mdl[i] = RV_A[i*8 +: 8];
      merr = 0;
   endtask
   task automatic wr_a(input logic [23:0] a, input logic [7:0] d);
      bit ok;
      int wa;
      ok = (a < 8) && !RO_A[a[2:0]];
      wa = ok ? int'(a) : -1;
      @(negedge clk);
      addr_a = a; wdata_a = d; wr_en_a = 1;
      repeat (3) @(posedge clk);
      #1;
      if (!ok && merr < 255) merr++;
      chk("wr_regs", regs_a, flat_a(wa, d));
      chk("wr_strobe", strobe_a, ok ? (8'd1 << a[2:0]) : 8'd0);
      chk("wr_err", err_a, merr);
      if (ok && !SC_A[a[2:0]]) mdl[a[2:0]] = d;
      @(posedge clk);
      #1;
      chk("strobe_clr", strobe_a, 0);
      chk("regs_after", regs_a, flat_a(-1, 0));
      @(negedge clk);
      wr_en_a = 0;
      repeat (3) @(posedge clk);
   endtask
   task automatic rd_a(input logic [23:0] a, output logic [7:0] got);
      logic [7:0] exp;
      exp = (a >= 8) ? 8'h0 : RO_A[a[2:0]] ? status_a[a[2:0]*8 +: 8] : mdl[a[2:0]];
      @(negedge clk);
      addr_a = a; rd_en_a = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rd_data", rdata_a, exp);
      got = rdata_a;
      @(negedge clk);
      rd_en_a = 0;
      repeat (3) @(posedge clk);
   endtask
   typedef struct {
      bit          wr;
      logic [23:0] a;
      logic [7:0]  d;
      logic [7:0]  exp;
   } vec_t;
   vec_t tbl [13];
   initial begin
      logic [7:0] got, old;
      int np;
      tbl[0]  = '{1'b1, 24'h3,   8'hA5, 8'd0};
      tbl[1]  = '{1'b0, 24'h3,   8'h00, 8'hA5};
      tbl[2]  = '{1'b0, 24'h7,   8'h00, 8'h5C};
      tbl[3]  = '{1'b1, 24'h7,   8'hFF, 8'd1};
      tbl[4]  = '{1'b0, 24'h7,   8'h00, 8'h5C};
      tbl[5]  = '{1'b1, 24'h100, 8'h12, 8'd2};
      tbl[6]  = '{1'b1, 24'h8,   8'h34, 8'd3};
      tbl[7]  = '{1'b0, 24'h100, 8'h00, 8'h00};
      tbl[8]  = '{1'b0, 24'h1,   8'h00, 8'h42};
      tbl[9]  = '{1'b1, 24'h1,   8'h77, 8'd3};
      tbl[10] = '{1'b0, 24'h1,   8'h00, 8'h77};
      tbl[11] = '{1'b1, 24'h0,   8'h03, 8'd3};
      tbl[12] = '{1'b0, 24'h0,   8'h00, 8'h00};
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_regs_a", regs_a, flat_a(-1, 0));
      chk("rst_rdata_a", rdata_a, 0);
      chk("rst_strobe_a", strobe_a, 0);
      chk("rst_err_a", err_a, 0);
      chk("rst_regs_b", regs_b, RV_B);
      @(negedge clk);
      rst_n = 1;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 13; i++) begin
         if (tbl[i].wr) begin
            wr_a(tbl[i].a, tbl[i].d);
            chk("tbl_err", err_a, tbl[i].exp);
         end else begin
            rd_a(tbl[i].a, got);
            chk("tbl_rd", got, tbl[i].exp);
         end
      end
      // held strobe: one write only, data captured at the pulse
      @(negedge clk);
      addr_a = 24'h2; wdata_a = 8'h3C; wr_en_a = 1;
      np = 0;
      for (int c = 0; c < 24; c++) begin
         @(posedge clk);
         #1;
         if (strobe_a[2]) np++;
         if (c == 8) wdata_a = 8'h11;
      end
      mdl[2] = 8'h3C;
      chk("held_pulses", np, 1);
      chk("held_regs", regs_a, flat_a(-1, 0));
      @(negedge clk);
      wr_en_a = 0;
      repeat (3) @(posedge clk);
      // simultaneous read and write of the same register
      old = mdl[4];
      @(negedge clk);
      addr_a = 24'h4; wdata_a = 8'h9D; wr_en_a = 1; rd_en_a = 1;
      repeat (3) @(posedge clk);
      #1;
      mdl[4] = 8'h9D;
      chk("rw_rdata_old", rdata_a, old);
      chk("rw_regs_new", regs_a, flat_a(-1, 0));
      @(negedge clk);
      wr_en_a = 0; rd_en_a = 0;
      repeat (3) @(posedge clk);
      for (int i = 0; i < 60; i++) begin
         logic [23:0] a;
         status_a = {$urandom, $urandom};
         a = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 9));
         if ($urandom_range(0, 1) == 1) wr_a(a, 8'($urandom));
         else rd_a(a, got);
      end
      for (int i = 0; i < 260; i++) wr_a(24'h9, 8'(i));
      chk("err_sat", err_a, 255);
      @(negedge clk);
      addr_b = 24'd31; wdata_b = 16'hBEEF; wr_en_b = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("b_wr_reg31", regs_b[511:496], 16'hBEEF);
      chk("b_wr_strobe", strobe_b, 32'h8000_0000);
      @(negedge clk);
      wr_en_b = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rd_en_b = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("b_rd_31", rdata_b, 16'hBEEF);
      @(negedge clk);
      rd_en_b = 0;
      repeat (3) @(posedge clk);
      // reset in the middle of a read, strobe kept high across release
      @(negedge clk);
      rd_en_b = 1;
      @(posedge clk);
      @(negedge clk);
      rst_n = 0;
      #1;
      model_reset();
      chk("b_rst_rdata", rdata_b, 0);
      chk("b_rst_regs", regs_b, RV_B);
      chk("a_rst_regs", regs_a, flat_a(-1, 0));
      chk("a_rst_err", err_a, 0);
      chk("a_rst_rdata", rdata_a, 0);
      @(negedge clk);
      rst_n = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("b_reread_31", rdata_b, 16'h1234);
      @(negedge clk);
      rd_en_b = 0;
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
